// File: rtl/score_ssd_pkg.sv
// Shared definitions for the score seven-segment driver.
//   - engine FSM state encodings
//   - saturation limit for the 4-digit display
//   - active-low 7-seg patterns {a,b,c,d,e,f,g} and the blank pattern
package score_ssd_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int         SAT_MAX   = 9999;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low cathodes; non-decimal nibbles render as blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b0000001;
            4'd1:    seg_decode = 7'b1001111;
            4'd2:    seg_decode = 7'b0010010;
            4'd3:    seg_decode = 7'b0000110;
            4'd4:    seg_decode = 7'b1001100;
            4'd5:    seg_decode = 7'b0100100;
            4'd6:    seg_decode = 7'b0100000;
            4'd7:    seg_decode = 7'b0001111;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0000100;
            default: seg_decode = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/score_ssd_driver_bin2bcd_seq.sv
// Sequential double-dabble converter with a one-deep request queue.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   start       conversion request (pulse or level)
//   din         binary score, saturated to 9999 on capture
//   busy        high while converting or committing
//   bcd         committed BCD result {d3,d2,d1,d0}
//   ovf         last committed score exceeded 9999
module bin2bcd_seq
    import score_ssd_pkg::*;
#(
    parameter int SCORE_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [SCORE_W-1:0] din,
    output logic               busy,
    output logic [15:0]        bcd,
    output logic               ovf
);

    logic [1:0]         state;
    logic [3:0]         iter;
    logic [15:0]        sh_bcd;
    logic [15:0]        sh_bin;
    logic [15:0]        adj;
    logic               ovf_next;
    logic               pending;
    logic [SCORE_W-1:0] pend_score;

    // Sources for the next capture: a request arriving in DONE beats an
    // older queued one, since it is the most recent write.
    logic [SCORE_W-1:0] load_val;
    logic               load_ovf;
    logic [15:0]        load_bin;

    always_comb begin
        load_val = start ? din : pend_score;
        load_ovf = (32'(load_val) > SAT_MAX);
        load_bin = load_ovf ? 16'(SAT_MAX) : 16'(load_val);
    end

    // Add-3 correction on every nibble that would exceed 9 after the shift.
    always_comb begin
        adj = sh_bcd;
        for (int n = 0; n < 4; n++) begin
            if (sh_bcd[n*4 +: 4] >= 4'd5)
                adj[n*4 +: 4] = sh_bcd[n*4 +: 4] + 4'd3;
        end
    end

    assign busy = (state == ST_CONV) || (state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            iter       <= '0;
            sh_bcd     <= '0;
            sh_bin     <= '0;
            ovf_next   <= 1'b0;
            pending    <= 1'b0;
            pend_score <= '0;
            bcd        <= '0;
            ovf        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sh_bcd   <= '0;
                        sh_bin   <= load_bin;
                        ovf_next <= load_ovf;
                        iter     <= '0;
                        state    <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    if (start) begin
                        pending    <= 1'b1;
                        pend_score <= din;
                    end
                    {sh_bcd, sh_bin} <= {adj, sh_bin} << 1;
                    iter <= iter + 4'd1;
                    if (iter == 4'd15)
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    bcd <= sh_bcd;
                    ovf <= ovf_next;
                    if (start || pending) begin
                        pending  <= 1'b0;
                        sh_bcd   <= '0;
                        sh_bin   <= load_bin;
                        ovf_next <= load_ovf;
                        iter     <= '0;
                        state    <= ST_CONV;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/score_ssd_driver.sv
// Score display driver: converts a binary score to BCD and scans it onto
// four active-low seven-segment digits.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   score        binary score, sampled when score_valid=1
//   score_valid  conversion request
//   busy         conversion in progress
//   bcd          committed BCD digits {d3,d2,d1,d0}
//   overflow     last committed score was >9999
//   an           one-hot active-low anodes, an[0] = ones digit
//   seg          active-low cathodes {a,b,c,d,e,f,g}
//   dp           decimal point, always off
module score_ssd_driver
    import score_ssd_pkg::*;
#(
    parameter int SCORE_W       = 16,
    parameter int SCAN_BITS     = 20,
    parameter int BLANK_LEADING = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [SCORE_W-1:0] score,
    input  logic               score_valid,
    output logic               busy,
    output logic [15:0]        bcd,
    output logic               overflow,
    output logic [3:0]         an,
    output logic [6:0]         seg,
    output logic               dp
);

    bin2bcd_seq #(.SCORE_W(SCORE_W)) u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (score_valid),
        .din   (score),
        .busy  (busy),
        .bcd   (bcd),
        .ovf   (overflow)
    );

    logic [SCAN_BITS-1:0] cnt;
    logic [1:0]           sel;
    logic [15:0]          upper;
    logic                 blank;

    assign sel = cnt[SCAN_BITS-1 -: 2];

    // upper[3:0] is the selected digit; the rest are the digits above it,
    // so the digit is a leading zero when the whole of upper is zero.
    assign upper = bcd >> {sel, 2'b00};
    assign blank = (BLANK_LEADING != 0) && (sel != 2'd0) && (upper == 16'h0);

    assign dp = 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            an  <= 4'b1111;
            seg <= SEG_BLANK;
        end else begin
            cnt <= cnt + SCAN_BITS'(1);
            an  <= ~(4'b0001 << sel);
            seg <= blank ? SEG_BLANK : seg_decode(upper[3:0]);
        end
    end

endmodule

// File: tb/tb_score_ssd_driver.sv
module tb_score_ssd_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] score = '0;
    logic        score_valid = 1'b0;

    logic        busy, overflow, dp;
    logic [15:0] bcd;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        busy0, overflow0, dp0;
    logic [15:0] bcd0;
    logic [3:0]  an0;
    logic [6:0]  seg0;

    score_ssd_driver #(.SCORE_W(16), .SCAN_BITS(4), .BLANK_LEADING(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .score(score), .score_valid(score_valid),
        .busy(busy), .bcd(bcd), .overflow(overflow), .an(an), .seg(seg), .dp(dp)
    );

    score_ssd_driver #(.SCORE_W(16), .SCAN_BITS(4), .BLANK_LEADING(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .score(score), .score_valid(score_valid),
        .busy(busy0), .bcd(bcd0), .overflow(overflow0), .an(an0), .seg(seg0), .dp(dp0)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int rel_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        int          cyc;
    } exp_t;
    exp_t q[$];

    bit          mon_en = 1'b0;
    logic [15:0] last_bcd = '0;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'b0000001;
            4'd1: return 7'b1001111;
            4'd2: return 7'b0010010;
            4'd3: return 7'b0000110;
            4'd4: return 7'b1001100;
            4'd7: return 7'b0001111;
            default: return 7'h7F;
        endcase
    endfunction

    // Scoreboard: a commit must happen exactly on the predicted cycle, and
    // bcd must not move at any other time.
    always @(negedge clk) begin
        if (mon_en) begin
            if (q.size() > 0 && cyc == q[0].cyc) begin
                n_chk++;
                if (bcd !== q[0].bcd || overflow !== q[0].ovf) begin
                    n_fail++;
                    $display("FAIL commit @%0d: bcd=%h ovf=%b, expected bcd=%h ovf=%b",
                             cyc, bcd, overflow, q[0].bcd, q[0].ovf);
                end
                void'(q.pop_front());
            end else if (bcd !== last_bcd) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_commit @%0d: bcd=%h, expected unchanged %h",
                         cyc, bcd, last_bcd);
            end
        end
        last_bcd = bcd;
    end

    task automatic push_exp(input logic [15:0] b, input logic o, input int c);
        exp_t e;
        e.bcd = b; e.ovf = o; e.cyc = c;
        q.push_back(e);
    endtask

    // Starts just after a negedge; the request is seen at the next posedge.
    task automatic pulse(input logic [15:0] s);
        score = s;
        score_valid = 1'b1;
        @(negedge clk);
        score_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && q.size() != 0; i++) @(negedge clk);
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d commits outstanding, expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({busy, bcd, overflow, an, seg, dp} !== {1'b0, 16'h0, 1'b0, 4'b1111, 7'h7F, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_values: busy=%b bcd=%h ovf=%b an=%b seg=%h dp=%b, expected 0 0000 0 1111 7f 1",
                     busy, bcd, overflow, an, seg, dp);
        end
        n_chk++;
        if (dp0 !== 1'b1 || an0 !== 4'b1111) begin
            n_fail++;
            $display("FAIL reset_dut0: an=%b dp=%b, expected 1111 1", an0, dp0);
        end
        rst_n = 1'b1;
        rel_cyc = cyc;
        mon_en = 1'b1;
    endtask

    task automatic test_convert;
        int busy_cnt;
        busy_cnt = 0;
        push_exp(16'h1234, 1'b0, cyc + 18);
        pulse(16'h04D2);
        for (int i = 0; i < 20; i++) begin
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
        end
        n_chk++;
        if (busy_cnt != 17) begin
            n_fail++;
            $display("FAIL busy_length: %0d cycles, expected 17", busy_cnt);
        end
        wait_drain(40);
    endtask

    task automatic test_saturate;
        push_exp(16'h9999, 1'b1, cyc + 18);
        pulse(16'hFFFF);
        wait_drain(40);
        push_exp(16'h9999, 1'b0, cyc + 18);
        pulse(16'd9999);
        wait_drain(40);
        push_exp(16'h0007, 1'b0, cyc + 18);
        pulse(16'd7);
        wait_drain(40);
    endtask

    // Both instances hold 0007; check scan order and leading-zero blanking.
    task automatic test_blanking;
        int e, k;
        logic [3:0] exp_an;
        logic [6:0] exp1, exp0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            e = cyc - rel_cyc;
            k = ((e - 1) >> 2) & 3;
            exp_an = ~(4'b0001 << k);
            exp1 = (k == 0) ? seg_of(4'd7) : 7'h7F;
            exp0 = (k == 0) ? seg_of(4'd7) : seg_of(4'd0);
            n_chk++;
            if (an !== exp_an || seg !== exp1) begin
                n_fail++;
                $display("FAIL blank_on: an=%b seg=%h, expected an=%b seg=%h", an, seg, exp_an, exp1);
            end
            n_chk++;
            if (an0 !== exp_an || seg0 !== exp0) begin
                n_fail++;
                $display("FAIL blank_off: an=%b seg=%h, expected an=%b seg=%h", an0, seg0, exp_an, exp0);
            end
        end
    endtask

    task automatic test_scan;
        int e, k;
        logic [3:0] exp_an, prev_an;
        logic [6:0] exp_seg, prev_seg;
        push_exp(16'h1234, 1'b0, cyc + 18);
        pulse(16'd1234);
        wait_drain(40);
        prev_an = an;
        prev_seg = seg;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            e = cyc - rel_cyc;
            k = ((e - 1) >> 2) & 3;
            exp_an = ~(4'b0001 << k);
            exp_seg = seg_of(4'(16'h1234 >> (4 * k)));
            n_chk++;
            if (an !== exp_an || seg !== exp_seg) begin
                n_fail++;
                $display("FAIL scan @%0d: an=%b seg=%h, expected an=%b seg=%h", e, an, seg, exp_an, exp_seg);
            end
            n_chk++;
            if ((seg !== prev_seg) && (an === prev_an)) begin
                n_fail++;
                $display("FAIL scan_align: seg %h->%h while an stayed %b, expected same-edge change",
                         prev_seg, seg, an);
            end
            prev_an = an;
            prev_seg = seg;
        end
    endtask

    task automatic test_back_to_back;
        int k, low;
        k = cyc;
        low = 0;
        push_exp(16'h0010, 1'b0, k + 18);
        push_exp(16'h0030, 1'b0, k + 35);
        score = 16'd10;
        score_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            score_valid = 1'b0;
            if (cyc == k + 3) begin score = 16'd20; score_valid = 1'b1; end
            if (cyc == k + 5) begin score = 16'd30; score_valid = 1'b1; end
            if (cyc >= k + 1 && cyc <= k + 34 && busy !== 1'b1) low++;
        end
        n_chk++;
        if (low != 0) begin
            n_fail++;
            $display("FAIL b2b_busy: busy low %0d cycles, expected 0", low);
        end
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: busy=%b, expected 0", busy);
        end
        wait_drain(10);
    endtask

    task automatic test_reset_mid;
        int k;
        mon_en = 1'b0;
        k = cyc;
        score = 16'd4321;
        score_valid = 1'b1;
        while (cyc < k + 10) begin
            @(negedge clk);
            score_valid = 1'b0;
            if (cyc == k + 3) begin score = 16'd55; score_valid = 1'b1; end
        end
        n_chk++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_busy: busy=%b, expected 1", busy);
        end
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({busy, bcd, overflow, an, seg} !== {1'b0, 16'h0, 1'b0, 4'b1111, 7'h7F}) begin
            n_fail++;
            $display("FAIL mid_reset: busy=%b bcd=%h ovf=%b an=%b seg=%h, expected 0 0000 0 1111 7f",
                     busy, bcd, overflow, an, seg);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rel_cyc = cyc;
        repeat (40) @(negedge clk);
        n_chk++;
        if (bcd !== 16'h0 || busy !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset: bcd=%h busy=%b ovf=%b, expected 0000 0 0", bcd, busy, overflow);
        end
        mon_en = 1'b1;
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_convert();
        test_saturate();
        test_blanking();
        test_scan();
        test_back_to_back();
        test_reset_mid();
        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
